// File: rtl/mem_access_ctrl.sv
// Multicycle data-memory load/store controller: issues one word-aligned access, waits on mem_rdy
// (with optional timeout), and returns extended load data. Define UNALIGNED_TRAP_EN to trap misaligned ops.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [5:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rdy
);
    localparam logic [5:0] OpLb  = 6'h20;
    localparam logic [5:0] OpLh  = 6'h21;
    localparam logic [5:0] OpLw  = 6'h23;
    localparam logic [5:0] OpLbu = 6'h24;
    localparam logic [5:0] OpLhu = 6'h25;
    localparam logic [5:0] OpSb  = 6'h28;
    localparam logic [5:0] OpSh  = 6'h29;
    localparam logic [5:0] OpSw  = 6'h2B;

    localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StDone, StErr} state_e;

    state_e        state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [5:0]    op_q, op_d;
    logic [1:0]    a_q, a_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic          mem_we_q, mem_we_d;
    logic [3:0]    mem_be_q, mem_be_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;

    logic          legal, is_store, misalign;
    logic [3:0]    be_st;
    logic [31:0]   wdata_st, ld_ext;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;

    // Request-side decode: legality, alignment, store lane replication.
    always_comb begin
        legal    = 1'b1;
        is_store = 1'b0;
        misalign = 1'b0;
        be_st    = 4'b0000;
        wdata_st = 32'h0;
        unique case (op)
            OpLb, OpLbu: ;
            OpLh, OpLhu: begin
`ifdef UNALIGNED_TRAP_EN
                misalign = addr[0];
`endif
            end
            OpLw: begin
`ifdef UNALIGNED_TRAP_EN
                misalign = |addr[1:0];
`endif
            end
            OpSb: begin
                is_store = 1'b1;
                be_st    = 4'b0001 << addr[1:0];
                wdata_st = {4{wdata[7:0]}};
            end
            OpSh: begin
                is_store = 1'b1;
                be_st    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_st = {2{wdata[15:0]}};
`ifdef UNALIGNED_TRAP_EN
                misalign = addr[0];
`endif
            end
            OpSw: begin
                is_store = 1'b1;
                be_st    = 4'b1111;
                wdata_st = wdata;
`ifdef UNALIGNED_TRAP_EN
                misalign = |addr[1:0];
`endif
            end
            default: legal = 1'b0;
        endcase
    end

    // Load lane select and extension, from the latched op and byte offset.
    always_comb begin
        ld_byte = mem_rdata[8*a_q +: 8];
        ld_half = a_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        unique case (op_q)
            OpLb:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
            OpLbu:   ld_ext = {24'h0, ld_byte};
            OpLh:    ld_ext = {{16{ld_half[15]}}, ld_half};
            OpLhu:   ld_ext = {16'h0, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        a_d         = a_q;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (!legal || misalign) begin
                        state_d = StErr;
                    end else begin
                        state_d     = StAccess;
                        cnt_d       = '0;
                        op_d        = op;
                        a_d         = addr[1:0];
                        mem_addr_d  = {addr[31:2], 2'b00};
                        mem_we_d    = is_store;
                        mem_be_d    = be_st;
                        mem_wdata_d = wdata_st;
                    end
                end
            end
            StAccess: begin
                if (mem_rdy) begin
                    if (!op_q[3]) rdata_d = ld_ext;
                    state_d = StDone;
                end else if ((TIMEOUT != 0) && (cnt_q == CntLast)) begin
                    state_d = StErr;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            op_q        <= 6'h0;
            a_q         <= 2'b00;
            rdata_q     <= 32'h0;
            mem_addr_q  <= 32'h0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            a_q         <= a_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign err       = (state_q == StErr);
    assign mem_en    = (state_q == StAccess);
    assign rdata     = rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed plan cases plus random accesses against a behavioural model.
module tb_mem_access_ctrl;
    localparam int unsigned TO = 4;

    logic        clk, rst_n, req;
    logic [5:0]  op;
    logic [31:0] addr, wdata, mem_rdata;
    logic        mem_rdy;
    logic        busy, done, err, mem_en, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    mem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .op(op), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .err(err), .rdata(rdata), .mem_addr(mem_addr),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rdy(mem_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_rdata = 32'h0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_load(input logic [5:0] o);
        return o inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    endfunction

    function automatic bit is_store(input logic [5:0] o);
        return o inside {6'h28, 6'h29, 6'h2B};
    endfunction

    function automatic bit traps(input logic [5:0] o, input logic [1:0] a);
`ifdef UNALIGNED_TRAP_EN
        if (o inside {6'h21, 6'h25, 6'h29}) return a[0];
        if (o inside {6'h23, 6'h2B}) return a != 2'b00;
`endif
        return (o == 6'h3F) && (a == 2'b11) && 1'b0;
    endfunction

    function automatic logic [31:0] ld_val(input logic [5:0] o, input logic [1:0] a,
                                           input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> (8 * int'(a)));
        h = 16'(w >> (16 * int'(a[1])));
        case (o)
            6'h20:   return {{24{b[7]}}, b};
            6'h24:   return {24'h0, b};
            6'h21:   return {{16{h[15]}}, h};
            6'h25:   return {16'h0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] st_be(input logic [5:0] o, input logic [1:0] a);
        case (o)
            6'h28:   return 4'(1 << int'(a));
            6'h29:   return 4'(3 << (2 * int'(a[1])));
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] st_data(input logic [5:0] o, input logic [31:0] d);
        case (o)
            6'h28:   return {24'h0, d[7:0]} * 32'h0101_0101;
            6'h29:   return {16'h0, d[15:0]} * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_err"}, 32'(err), 32'h0);
        chk({tag, "_rdata"}, rdata, 32'h0);
        chk({tag, "_maddr"}, mem_addr, 32'h0);
        chk({tag, "_men"}, 32'(mem_en), 32'h0);
        chk({tag, "_mwe"}, 32'(mem_we), 32'h0);
        chk({tag, "_mbe"}, 32'(mem_be), 32'h0);
        chk({tag, "_mwdata"}, mem_wdata, 32'h0);
    endtask

    // One request; lat = ACCESS cycle in which mem_rdy pulses, outside 1..TO means never.
    task automatic run(input logic [5:0] o, input logic [31:0] ad, input logic [31:0] wd,
                       input logic [31:0] word, input int lat);
        bit ok;
        req = 1'b1; op = o; addr = ad; wdata = wd;
        tick();
        req = 1'b0; op = $urandom; addr = $urandom; wdata = $urandom;
        if (!(is_load(o) || is_store(o)) || traps(o, ad[1:0])) begin
            chk("dec_err", 32'(err), 32'h1);
            chk("dec_men", 32'(mem_en), 32'h0);
            tick();
            chk("dec_idle", 32'(busy), 32'h0);
            chk("dec_rdata", rdata, exp_rdata);
            return;
        end
        ok = (lat >= 1) && (lat <= int'(TO));
        for (int k = 1; k <= int'(TO); k++) begin
            chk("acc_men", 32'(mem_en), 32'h1);
            if (k == 1) begin
                chk("acc_maddr", mem_addr, {ad[31:2], 2'b00});
                chk("acc_mwe", 32'(mem_we), 32'(is_store(o)));
                chk("acc_mbe", 32'(mem_be), is_store(o) ? 32'(st_be(o, ad[1:0])) : 32'h0);
                if (is_store(o)) chk("acc_mwdata", mem_wdata, st_data(o, wd));
            end
            mem_rdy = (k == lat);
            mem_rdata = (k == lat) ? word : $urandom;
            tick();
            mem_rdy = 1'b0;
            if (k == lat) break;
        end
        if (ok) begin
            if (is_load(o)) exp_rdata = ld_val(o, ad[1:0], word);
            chk("fin_done", 32'(done), 32'h1);
            chk("fin_err", 32'(err), 32'h0);
        end else begin
            chk("fin_err", 32'(err), 32'h1);
            chk("fin_done", 32'(done), 32'h0);
        end
        chk("fin_busy", 32'(busy), 32'h1);
        chk("fin_men", 32'(mem_en), 32'h0);
        chk("fin_rdata", rdata, exp_rdata);
        tick();
        chk("idle_busy", 32'(busy), 32'h0);
        chk("idle_rdata", rdata, exp_rdata);
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; op = 6'h0; addr = 32'h0; wdata = 32'h0;
        mem_rdata = 32'h0; mem_rdy = 1'b0;
        tick();
        tick();
        chk_zero("rst");
        rst_n = 1'b1;
        tick();

        run(6'h20, 32'h0000_0101, 32'h0, 32'h1234_8056, 1);
        chk("plan_lb", rdata, 32'hFFFF_FF80);
        run(6'h24, 32'h0000_0101, 32'h0, 32'h1234_8056, 1);
        chk("plan_lbu", rdata, 32'h0000_0080);
        run(6'h21, 32'h0000_0102, 32'h0, 32'h1234_8056, 2);
        chk("plan_lh_hi", rdata, 32'h0000_1234);
        run(6'h25, 32'h0000_0100, 32'h0, 32'h0000_F00D, 1);
        chk("plan_lhu", rdata, 32'h0000_F00D);
        run(6'h21, 32'h0000_0100, 32'h0, 32'h0000_F00D, 3);
        chk("plan_lh_lo", rdata, 32'hFFFF_F00D);
        run(6'h29, 32'h0000_0102, 32'h0000_ABCD, 32'h0, 1);
        run(6'h23, 32'h0000_0102, 32'h0, 32'hCAFE_F00D, 2);
        run(6'h23, 32'h0000_0200, 32'h0, 32'h0BAD_BEEF, 0);
        run(6'h23, 32'h0000_0204, 32'h0, 32'h1357_9BDF, 4);
        run(6'h3F, 32'h0000_0000, 32'h0, 32'h0, 1);

        // Reset in cycle 2 of an access that would otherwise run 5 cycles.
        req = 1'b1; op = 6'h23; addr = 32'h0000_0300;
        tick();
        req = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_rdata = 32'h0;
        chk_zero("midrst");
        tick();
        chk("midrst_done", 32'(done), 32'h0);
        chk("midrst_err", 32'(err), 32'h0);
        run(6'h2B, 32'h0000_0304, 32'h89AB_CDEF, 32'h0, 2);

        for (int i = 0; i < 60; i++) begin
            logic [5:0] ops [8];
            int sel;
            logic [5:0] o;
            ops = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
            sel = int'($urandom_range(0, 9));
            o = (sel < 8) ? ops[sel] : 6'($urandom);
            run(o, $urandom, $urandom, $urandom, int'($urandom_range(0, 5)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
